// File: rtl/bram_arb_pkg.sv
// Shared types and round-robin helper for the BRAM port arbiters.
// Parity lanes in bram_cmd_t exist only when BRAM_ARB_PARITY_EN is defined.
package bram_arb_pkg;

  localparam int unsigned BRAM_BE_W   = 4;
  localparam int unsigned BRAM_PAR_W  = 4;
  localparam int unsigned BRAM_ADDR_W = 15;
  localparam int unsigned BRAM_DATA_W = 32;

  localparam int unsigned RR_MAX_REQ  = 8;
  localparam int unsigned RR_PTR_W    = 3;

  typedef enum logic {
    BRAM_OP_READ  = 1'b0,
    BRAM_OP_WRITE = 1'b1
  } bram_op_t;

  typedef struct packed {
    bram_op_t                we;
    logic [BRAM_ADDR_W-1:0]  addr;
    logic [BRAM_BE_W-1:0]    be;
    logic [BRAM_DATA_W-1:0]  wdata;
`ifdef BRAM_ARB_PARITY_EN
    logic [BRAM_PAR_W-1:0]   wparity;
`endif
  } bram_cmd_t;

  // Searching modulo 8 equals searching modulo NUM_REQ as long as the
  // caller zero-pads valid above NUM_REQ and keeps ptr below NUM_REQ.
  function automatic logic [RR_MAX_REQ-1:0] rr_next(
    input logic [RR_PTR_W-1:0]   ptr,
    input logic [RR_MAX_REQ-1:0] valid
  );
    logic [RR_MAX_REQ-1:0] grant;
    logic [RR_PTR_W-1:0]   idx;
    logic                  found;
    grant = '0;
    found = 1'b0;
    idx   = ptr;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
      idx = idx + RR_PTR_W'(1);
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant with a registered priority pointer.
// The pointer moves past the winner whenever a grant is issued.
module rr_grant
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_nxt;
  logic [RR_MAX_REQ-1:0] valid_pad;
  logic [RR_MAX_REQ-1:0] grant_pad;

  always_comb begin
    valid_pad              = '0;
    valid_pad[NUM_REQ-1:0] = valid;
    grant_pad              = reset ? '0 : rr_next(RR_PTR_W'(ptr), valid_pad);
    grant                  = grant_pad[NUM_REQ-1:0];
  end

  always_comb begin
    ptr_nxt = ptr;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      if (grant_pad[k]) begin
        ptr_nxt = (k + 1 >= NUM_REQ) ? '0 : PTR_W'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one TDP_RAM36K port between NUM_REQ requesters.
// Define BRAM_ARB_PARITY_EN to carry the 4-bit parity lanes alongside data.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*BRAM_BE_W-1:0]  req_be,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
`ifdef BRAM_ARB_PARITY_EN
  input  logic [NUM_REQ*BRAM_PAR_W-1:0] req_wparity,
`endif
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
`ifdef BRAM_ARB_PARITY_EN
  output logic [BRAM_PAR_W-1:0]         rsp_rparity,
`endif
  output logic                          ram_wen,
  output logic                          ram_ren,
  output logic [BRAM_BE_W-1:0]          ram_be,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
`ifdef BRAM_ARB_PARITY_EN
  output logic [BRAM_PAR_W-1:0]         ram_wparity,
`endif
  input  logic [DATA_W-1:0]             ram_rdata
`ifdef BRAM_ARB_PARITY_EN
  ,
  input  logic [BRAM_PAR_W-1:0]         ram_rparity
`endif
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  logic [ID_W-1:0]    grant_id;
  bram_cmd_t          cmd_d;
  bram_cmd_t          cmd_q;
  logic               cmd_vld_q;
  logic [ID_W-1:0]    cmd_id_q;
  tag_t               tag_q [RD_LATENCY];

  rr_grant #(.NUM_REQ(NUM_REQ)) u_rr_grant (
    .clk   (clk),
    .reset (reset),
    .valid (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    cmd_d    = '0;
    grant_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id      = ID_W'(i);
        cmd_d.we      = bram_op_t'(req_we[i]);
        cmd_d.addr    = BRAM_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
        cmd_d.be      = req_we[i] ? req_be[i*BRAM_BE_W +: BRAM_BE_W] : '0;
        cmd_d.wdata   = BRAM_DATA_W'(req_wdata[i*DATA_W +: DATA_W]);
`ifdef BRAM_ARB_PARITY_EN
        cmd_d.wparity = req_wparity[i*BRAM_PAR_W +: BRAM_PAR_W];
`endif
      end
    end
  end

  // Payload holds across idle cycles; only the valid flag drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q     <= '0;
      cmd_vld_q <= 1'b0;
      cmd_id_q  <= '0;
    end else begin
      cmd_vld_q <= xfer;
      if (xfer) begin
        cmd_q    <= cmd_d;
        cmd_id_q <= grant_id;
      end
    end
  end

  assign ram_wen   = cmd_vld_q && (cmd_q.we == BRAM_OP_WRITE);
  assign ram_ren   = cmd_vld_q && (cmd_q.we == BRAM_OP_READ);
  assign ram_be    = cmd_q.be;
  assign ram_addr  = cmd_q.addr[ADDR_W-1:0];
  assign ram_wdata = cmd_q.wdata[DATA_W-1:0];
`ifdef BRAM_ARB_PARITY_EN
  assign ram_wparity = cmd_q.wparity;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < RD_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= '{vld: ram_ren, id: cmd_id_q};
      for (int unsigned s = 1; s < RD_LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_q[RD_LATENCY-1].vld) begin
      rsp_valid[tag_q[RD_LATENCY-1].id] = 1'b1;
    end
  end

  assign rsp_rdata = ram_rdata;
`ifdef BRAM_ARB_PARITY_EN
  assign rsp_rparity = ram_rparity;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural RAM port model.
// With BRAM_ARB_PARITY_EN the RAM model runs at read latency 2 and parity is checked.
`timescale 1ns/1ps
module tb_bram_port_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned DATA_W  = 32;
`ifdef BRAM_ARB_PARITY_EN
  localparam int unsigned RD_LAT  = 2;
`else
  localparam int unsigned RD_LAT  = 1;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*4-1:0]      req_be;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      ram_wen;
  logic                      ram_ren;
  logic [3:0]                ram_be;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_wdata;
  logic [DATA_W-1:0]         ram_rdata;
`ifdef BRAM_ARB_PARITY_EN
  logic [NUM_REQ*4-1:0]      req_wparity;
  logic [3:0]                rsp_rparity;
  logic [3:0]                ram_wparity;
  logic [3:0]                ram_rparity;
`endif

  bram_port_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_be      (req_be),
    .req_wdata   (req_wdata),
`ifdef BRAM_ARB_PARITY_EN
    .req_wparity (req_wparity),
`endif
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
`ifdef BRAM_ARB_PARITY_EN
    .rsp_rparity (rsp_rparity),
`endif
    .ram_wen     (ram_wen),
    .ram_ren     (ram_ren),
    .ram_be      (ram_be),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
`ifdef BRAM_ARB_PARITY_EN
    .ram_wparity (ram_wparity),
`endif
    .ram_rdata   (ram_rdata)
`ifdef BRAM_ARB_PARITY_EN
    ,
    .ram_rparity (ram_rparity)
`endif
  );

  always #5 clk = ~clk;

  // RAM port model: byte-enabled writes, reads return after RD_LAT edges.
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;
  logic [3:0]        pl_par;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [2];
  logic [3:0]        pmem [0:(1<<ADDR_W)-1];
  logic [3:0]        prd_pipe [2];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr]  <= pl_data;
      pmem[pl_addr] <= pl_par;
    end else if (ram_wen) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
`ifdef BRAM_ARB_PARITY_EN
      pmem[ram_addr] <= ram_wparity;
`endif
    end
    rd_pipe[0]  <= mem[ram_addr];
    rd_pipe[1]  <= rd_pipe[0];
    prd_pipe[0] <= pmem[ram_addr];
    prd_pipe[1] <= prd_pipe[0];
  end

  assign ram_rdata = rd_pipe[RD_LAT-1];
`ifdef BRAM_ARB_PARITY_EN
  assign ram_rparity = prd_pipe[RD_LAT-1];
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
`ifdef BRAM_ARB_PARITY_EN
    req_wparity = '0;
`endif
  endtask

  task automatic set_req(input int unsigned i, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [3:0] be, input logic [DATA_W-1:0] d,
                         input logic [3:0] par = 4'h0);
    req_valid[i]                  = 1'b1;
    req_we[i]                     = we;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_be[i*4 +: 4]              = be;
    req_wdata[i*DATA_W +: DATA_W] = d;
`ifdef BRAM_ARB_PARITY_EN
    req_wparity[i*4 +: 4]         = par;
`else
    if (par != 4'h0) $display("note: parity ignored in this build");
`endif
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [3:0] p);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    pl_par  = p;
    tick();
    pl_en   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    pl_par  = '0;
    clear_reqs();

    preload(15'h0010, 32'hDEADBEEF, 4'h0);
    for (int unsigned i = 0; i < NUM_REQ; i++) preload(15'(32'h100 + i), 32'hC0DE0000 + i, 4'h0);
    preload(15'h0200, 32'h00000000, 4'h0);
    preload(15'h7FFF, 32'h0BAD0BAD, 4'h0);
    preload(15'h0020, 32'h5A5A5A5A, 4'b1010);

    // Reset state with every requester asking
    for (int unsigned i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 15'(32'h100 + i), 4'h0, 32'h0);
    @(negedge clk);
    check("rst_ready",  64'(req_ready), 64'(0));
    check("rst_wen",    64'(ram_wen),   64'(0));
    check("rst_ren",    64'(ram_ren),   64'(0));
    check("rst_addr",   64'(ram_addr),  64'(0));
    check("rst_be",     64'(ram_be),    64'(0));
    check("rst_wdata",  64'(ram_wdata), 64'(0));
    check("rst_rsp",    64'(rsp_valid), 64'(0));

    // Contention from reset release: grants rotate 0..3, reads return in order
    tick();
    reset = 1'b0;
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      check("rr_ready", 64'(req_ready), 64'(1) << (k % NUM_REQ));
      if (k >= 1 + RD_LAT) begin
        check("rr_rsp",   64'(rsp_valid), 64'(1) << ((k - 1 - RD_LAT) % NUM_REQ));
        check("rr_rdata", 64'(rsp_rdata), 64'(32'hC0DE0000 + (k - 1 - RD_LAT) % NUM_REQ));
      end
      tick();
    end
    clear_reqs();
    repeat (RD_LAT + 2) tick();

    // Single read by requester 1
    set_req(1, 1'b0, 15'h0010, 4'hF, 32'h0);
    @(negedge clk);
    check("single_ready", 64'(req_ready), 64'(4'b0010));
    tick();
    clear_reqs();
    @(negedge clk);
    check("single_ren",  64'(ram_ren),   64'(1));
    check("single_wen",  64'(ram_wen),   64'(0));
    check("single_addr", 64'(ram_addr),  64'(15'h0010));
    check("single_be",   64'(ram_be),    64'(0));
    check("single_early",64'(rsp_valid), 64'(0));
    repeat (RD_LAT) tick();
    @(negedge clk);
    check("single_rsp",   64'(rsp_valid), 64'(4'b0010));
    check("single_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
    tick();
    @(negedge clk);
    check("idle_ren",  64'(ram_ren),   64'(0));
    check("idle_addr", 64'(ram_addr),  64'(15'h0010));
    check("idle_rsp",  64'(rsp_valid), 64'(0));

    // Lone requester 0 wins every cycle although ptr points at 2
    for (int unsigned k = 0; k < 3; k++) begin
      set_req(0, 1'b1, 15'h0300, 4'hF, 32'h1 + k);
      @(negedge clk);
      check("lone_ready", 64'(req_ready), 64'(4'b0001));
      tick();
    end
    clear_reqs();
    tick();

    // Byte-enable write then back-to-back read from requester 3
    set_req(3, 1'b1, 15'h0200, 4'b0101, 32'hAABBCCDD);
    @(negedge clk);
    check("be_wr_ready", 64'(req_ready), 64'(4'b1000));
    tick();
    set_req(3, 1'b0, 15'h0200, 4'hF, 32'h0);
    @(negedge clk);
    check("be_wen",      64'(ram_wen),   64'(1));
    check("be_ren",      64'(ram_ren),   64'(0));
    check("be_be",       64'(ram_be),    64'(4'b0101));
    check("be_wdata",    64'(ram_wdata), 64'(32'hAABBCCDD));
    check("be_addr",     64'(ram_addr),  64'(15'h0200));
    check("be_rd_ready", 64'(req_ready), 64'(4'b1000));
    tick();
    clear_reqs();
    @(negedge clk);
    check("be_rd_ren", 64'(ram_ren), 64'(1));
    check("be_rd_be",  64'(ram_be),  64'(0));
    repeat (RD_LAT) tick();
    @(negedge clk);
    check("be_rsp",   64'(rsp_valid), 64'(4'b1000));
    check("be_rdata", 64'(rsp_rdata), 64'(32'h00BB00DD));
    tick();

    // Write by 0 then read by 2 of the same address
    set_req(0, 1'b1, 15'h7FFF, 4'hF, 32'h12345678);
    set_req(2, 1'b0, 15'h7FFF, 4'hF, 32'h0);
    @(negedge clk);
    check("haz_ready0", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("haz_ready2", 64'(req_ready), 64'(4'b0100));
    tick();
    clear_reqs();
    repeat (RD_LAT) tick();
    @(negedge clk);
    check("haz_rsp",   64'(rsp_valid), 64'(4'b0100));
    check("haz_rdata", 64'(rsp_rdata), 64'(32'h12345678));
    tick();

    // Reset one cycle after a read is accepted
    set_req(1, 1'b0, 15'h0010, 4'hF, 32'h0);
    @(negedge clk);
    check("mid_ready", 64'(req_ready), 64'(4'b0010));
    tick();
    clear_reqs();
    @(negedge clk);
    check("mid_ren_pre", 64'(ram_ren), 64'(1));
    reset = 1'b1;
    #1;
    check("mid_ren_async",  64'(ram_ren),  64'(0));
    check("mid_addr_async", 64'(ram_addr), 64'(0));
    tick();
    tick();
    reset = 1'b0;
    for (int unsigned k = 0; k < RD_LAT + 2; k++) begin
      @(negedge clk);
      check("mid_no_rsp", 64'(rsp_valid), 64'(0));
      tick();
    end
    @(negedge clk);
    check("mid_wen",   64'(ram_wen),   64'(0));
    check("mid_be",    64'(ram_be),    64'(0));
    check("mid_wdata", 64'(ram_wdata), 64'(0));
    for (int unsigned i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 15'(32'h100 + i), 4'h0, 32'h0);
    #1;
    check("mid_ptr0", 64'(req_ready), 64'(4'b0001));
    tick();
    clear_reqs();
    repeat (RD_LAT + 2) tick();

`ifdef BRAM_ARB_PARITY_EN
    // Parity lane rides with the read data
    set_req(2, 1'b0, 15'h0020, 4'hF, 32'h0);
    @(negedge clk);
    check("par_ready", 64'(req_ready), 64'(4'b0100));
    tick();
    clear_reqs();
    repeat (RD_LAT - 1) begin
      @(negedge clk);
      check("par_early", 64'(rsp_valid), 64'(0));
      tick();
    end
    tick();
    @(negedge clk);
    check("par_rsp",    64'(rsp_valid),   64'(4'b0100));
    check("par_rdata",  64'(rsp_rdata),   64'(32'h5A5A5A5A));
    check("par_parity", 64'(rsp_rparity), 64'(4'b1010));
    tick();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
